// File: rtl/bitty_exec_sequencer.sv
// bitty_exec_sequencer: fetch/execute/commit sequencer for the bitty core.
// Drives run_core and en_pc and handles run/stop, single-step, breakpoint
// and execute-timeout.
module bitty_exec_sequencer #(
  parameter int MEM_LAT = 1,   // cycles from PC update to valid memory data (1..7)
  parameter int TIMEOUT = 15,  // max EXEC cycles before error (1..255)
  parameter int CNT_W   = 16   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pc_addr,
  input  logic             core_done,
  output logic             run_core,
  output logic             en_pc,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state, state_nxt;
  logic [2:0] lat_cnt;
  logic [7:0] exec_tmr;
  logic       skip_bp;
  logic       bp_hit;

  // Suppressed for the single instruction resumed out of HALT so a
  // breakpoint on a self-loop does not re-halt immediately.
  assign bp_hit = bp_en && (pc_addr == bp_addr) && !skip_bp;

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      // lat_cnt==1 means this decrement takes it to zero: MEM_LAT cycles total
      S_FETCH:  if (lat_cnt == 3'd1) state_nxt = S_EXEC;
      // done beats the timeout when both land on the same cycle
      S_EXEC: begin
        if (core_done)                  state_nxt = S_COMMIT;
        else if (exec_tmr == TMO_LAST)  state_nxt = S_ERR;
      end
      S_COMMIT: begin
        if (!start)         state_nxt = S_IDLE;
        else if (bp_hit)    state_nxt = S_HALT;
        else if (step_mode) state_nxt = S_PAUSE;
        else                state_nxt = S_FETCH;
      end
      S_PAUSE: begin
        if (!start)                      state_nxt = S_IDLE;
        else if (step_req || !step_mode) state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (!start)         state_nxt = S_IDLE;
        else if (step_req)  state_nxt = S_FETCH;
      end
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Memory-latency countdown, reloaded on every entry to FETCH
  always_ff @(posedge clk) begin
    if (reset)                                           lat_cnt <= '0;
    else if (state_nxt == S_FETCH && state != S_FETCH)   lat_cnt <= LAT_LOAD;
    else if (state == S_FETCH)                           lat_cnt <= lat_cnt - 3'd1;
  end

  // Execute watchdog, cleared on every entry to EXEC
  always_ff @(posedge clk) begin
    if (reset)                                         exec_tmr <= '0;
    else if (state_nxt == S_EXEC && state != S_EXEC)   exec_tmr <= '0;
    else if (state == S_EXEC)                          exec_tmr <= exec_tmr + 8'd1;
  end

  // One-shot breakpoint bypass armed by a step out of HALT
  always_ff @(posedge clk) begin
    if (reset)                                      skip_bp <= 1'b0;
    else if (state == S_HALT && state_nxt == S_FETCH) skip_bp <= 1'b1;
    else if (state == S_COMMIT)                     skip_bp <= 1'b0;
  end

  // Saturating retired-instruction counter; only reset clears it
  always_ff @(posedge clk) begin
    if (reset)                                      instr_count <= '0;
    else if (state == S_COMMIT && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
  end

  // Outputs decode the state register only
  assign run_core    = (state == S_EXEC);
  assign en_pc       = (state == S_COMMIT);
  assign busy        = (state == S_FETCH) || (state == S_EXEC) || (state == S_COMMIT);
  assign halted      = (state == S_PAUSE) || (state == S_HALT);
  assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_bitty_exec_sequencer.sv
// Testbench for bitty_exec_sequencer: directed scenarios plus randomized
// instruction streams checked against instruction-level timing arithmetic.
module tb_bitty_exec_sequencer;
  localparam int MEM_LAT = 1;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, step_mode, step_req, bp_en, core_done;
  logic [7:0]       bp_addr, pc_addr;
  logic             run_core, en_pc, busy, halted, timeout_err;
  logic [CNT_W-1:0] instr_count;

  int total = 0, bad = 0;
  int cyc = 0, run_cnt = 0, last_run = 0, n_commit = 0, core_lat = 0, pc = 0;
  bit pend_inc = 0, pc_hold = 0, use_q = 0;
  int lats[16];
  int commit_cyc[$], commit_pc[$], run_lens[$];

  bitty_exec_sequencer #(.MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc_addr(pc_addr),
    .core_done(core_done), .run_core(run_core), .en_pc(en_pc), .busy(busy),
    .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: sample after the edge, advance PC / core model, record events
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (pend_inc) begin
      if (!pc_hold) pc++;
      pc_addr  = 8'(pc);
      pend_inc = 0;
    end
    if (use_q && n_commit < 16) core_lat = lats[n_commit];
    if (run_core) begin
      run_cnt++;
      core_done = (core_lat != 0) && (run_cnt == core_lat);
    end else begin
      if (run_cnt != 0) begin last_run = run_cnt; run_lens.push_back(run_cnt); end
      run_cnt   = 0;
      core_done = 1'b0;
    end
    if (en_pc) begin
      n_commit++;
      commit_cyc.push_back(cyc);
      commit_pc.push_back(pc);
      pend_inc = 1;
    end
    step_req = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    bp_en = 1'b0; bp_addr = 8'h00; core_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    run_cnt = 0; last_run = 0; n_commit = 0; core_lat = 0; pc = 0;
    pend_inc = 0; pc_hold = 0; use_q = 0; pc_addr = 8'h00;
    commit_cyc.delete(); commit_pc.delete(); run_lens.delete();
  endtask

  task automatic wait_commits(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_commit < n && k < budget) begin tick(); k++; end
    chk(tag, 32'(n_commit >= n), 32'd1);
  endtask

  initial begin
    int c0, t, okc, errs, n, bp, exp_n, e;
    bit exp_h, bpe;

    // reset state
    reset_dut();
    chk("reset_outputs", 32'({run_core, en_pc, busy, halted, timeout_err}), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);

    // free run: 4 instructions, 3-cycle core
    core_lat = 3; c0 = cyc; start = 1'b1;
    wait_commits(4, 100, "free_wait");
    start = 1'b0;
    chk("free_first", commit_cyc.size() > 0 ? commit_cyc[0] : -1, c0 + 1 + MEM_LAT + 3);
    errs = 0;
    for (int i = 1; i < 4; i++)
      if (commit_cyc.size() <= i || commit_cyc[i] - commit_cyc[i-1] != 5) errs++;
    for (int i = 0; i < 4; i++)
      if (run_lens.size() <= i || run_lens[i] != 3) errs++;
    chk("free_period_runlen", errs, 0);
    tick();
    chk("free_count", 32'(instr_count), 32'd4);
    chk("free_idle", 32'({busy, halted}), 32'd0);

    // step mode
    reset_dut();
    core_lat = 2; step_mode = 1'b1; start = 1'b1;
    wait_commits(1, 50, "step_wait1");
    tick();
    chk("step_count1", 32'(instr_count), 32'd1);
    okc = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted && !run_core && !en_pc) okc++;
      tick();
    end
    chk("step_paused20", okc, 20);
    step_req = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) tick();
    chk("step_one_more", n_commit, 2);
    chk("step_count2", 32'(instr_count), 32'd2);
    chk("step_paused_again", 32'(halted), 32'd1);

    // breakpoint at 3, pc advancing
    reset_dut();
    core_lat = 2; bp_en = 1'b1; bp_addr = 8'h03; start = 1'b1;
    t = 0; while (!halted && t < 200) begin tick(); t++; end
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_commits", n_commit, 4);
    chk("bp_count", 32'(instr_count), 32'd4);
    chk("bp_last_pc", commit_pc.size() > 3 ? commit_pc[3] : -1, 3);
    step_req = 1'b1;
    tick();
    wait_commits(5, 50, "bp_resume_wait");
    chk("bp_resume_pc", commit_pc.size() > 4 ? commit_pc[4] : -1, 4);
    tick(); tick();
    chk("bp_no_rehalt", 32'({halted, busy}), 32'b01);
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // breakpoint on a self-loop: resumed instruction must not re-halt
    reset_dut();
    core_lat = 1; pc_hold = 1; pc = 3; pc_addr = 8'h03;
    bp_en = 1'b1; bp_addr = 8'h03; start = 1'b1;
    t = 0; while (!halted && t < 50) begin tick(); t++; end
    chk("bploop_first", n_commit, 1);
    step_req = 1'b1;
    tick();
    t = 0; while (!halted && t < 100) begin tick(); t++; end
    chk("bploop_suppressed", n_commit, 3);
    chk("bploop_count", 32'(instr_count), 32'd3);

    // execute timeout
    reset_dut();
    core_lat = 0; start = 1'b1;
    t = 0; while (!timeout_err && t < 100) begin tick(); t++; end
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_run_off", 32'(run_core), 32'd0);
    chk("tmo_run_len", last_run, TIMEOUT);
    okc = 0;
    for (int i = 0; i < 50; i++) begin
      start    = 1'($urandom_range(0, 1));
      step_req = 1'($urandom_range(0, 1));
      tick();
      core_done = 1'($urandom_range(0, 1));
      if (timeout_err && !run_core && !en_pc && !busy && !halted) okc++;
    end
    chk("tmo_sticky50", okc, 50);
    chk("tmo_count", 32'(instr_count), 32'd0);
    reset_dut();
    chk("tmo_cleared", 32'({timeout_err, busy}), 32'd0);

    // done on the last allowed EXEC cycle wins over timeout
    core_lat = TIMEOUT; start = 1'b1;
    wait_commits(1, 60, "edge15_wait");
    start = 1'b0;
    tick();
    chk("edge15_no_err", 32'(timeout_err), 32'd0);
    chk("edge15_runlen", last_run, TIMEOUT);
    chk("edge15_count", 32'(instr_count), 32'd1);

    // one cycle too slow -> error
    reset_dut();
    core_lat = TIMEOUT + 1; start = 1'b1;
    t = 0; while (!timeout_err && t < 100) begin tick(); t++; end
    chk("edge16_err", 32'(timeout_err), 32'd1);
    chk("edge16_commits", n_commit, 0);

    // start dropped mid-EXEC: instruction still retires, then IDLE
    reset_dut();
    core_lat = 6; start = 1'b1;
    t = 0; while (!run_core && t < 20) begin tick(); t++; end
    tick(); tick();
    start = 1'b0;
    wait_commits(1, 30, "drop_wait");
    tick();
    chk("drop_idle", 32'({busy, halted}), 32'd0);
    chk("drop_count", 32'(instr_count), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("drop_no_more", n_commit, 1);

    // reset during EXEC
    reset_dut();
    core_lat = 2; start = 1'b1;
    wait_commits(2, 50, "rstx_wait");
    core_lat = 8;
    t = 0; while (!run_core && t < 20) begin tick(); t++; end
    tick(); tick();
    chk("rstx_pre_count", 32'(instr_count), 32'd2);
    reset = 1'b1;
    tick();
    chk("rstx_outputs", 32'({run_core, en_pc, busy, halted, timeout_err}), 32'd0);
    chk("rstx_count", 32'(instr_count), 32'd0);
    reset = 1'b0;

    // saturation
    reset_dut();
    core_lat = 1; start = 1'b1;
    wait_commits(20, 200, "sat_wait");
    start = 1'b0;
    tick();
    chk("sat_commits", n_commit, 20);
    chk("sat_count", 32'(instr_count), CNT_MAX);

    // randomized streams with random core latency and optional breakpoint
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      n   = $urandom_range(3, 8);
      bpe = 1'($urandom_range(0, 1));
      bp  = $urandom_range(0, 10);
      for (int i = 0; i < 16; i++) lats[i] = $urandom_range(1, 12);
      use_q = 1; bp_en = bpe; bp_addr = 8'(bp);
      exp_h = bpe && (bp < n - 1);
      exp_n = exp_h ? bp + 1 : n;
      c0 = cyc; start = 1'b1;
      t = 0; while (n_commit < n && !halted && t < 400) begin tick(); t++; end
      if (n_commit >= n) start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("rnd_commits", n_commit, exp_n);
      chk("rnd_halted", 32'(halted), 32'(exp_h));
      chk("rnd_count", 32'(instr_count), (exp_n > CNT_MAX) ? CNT_MAX : exp_n);
      errs = 0;
      for (int i = 0; i < exp_n; i++) begin
        if (i == 0) e = c0 + 1 + MEM_LAT + lats[0];
        else        e = (commit_cyc.size() > i - 1 ? commit_cyc[i-1] : 0) + MEM_LAT + lats[i] + 1;
        if (commit_cyc.size() <= i || commit_cyc[i] != e) errs++;
        if (run_lens.size() <= i || run_lens[i] != lats[i]) errs++;
      end
      chk("rnd_timing", errs, 0);
      start = 1'b0;
      tick();
      chk("rnd_idle", 32'({busy, halted}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
